// File: rtl/calc_port_arbiter.sv
// rtl/calc_port_arbiter.sv - four-port front end sharing one calc ALU.
// Each port runs a two-cycle capture FSM; PEND ports are round-robin issued and responses routed by tag.
module calc_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int DW      = 32
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic [3:0]    req1_cmd_in,
  input  logic [3:0]    req2_cmd_in,
  input  logic [3:0]    req3_cmd_in,
  input  logic [3:0]    req4_cmd_in,
  input  logic [DW-1:0] req1_data_in,
  input  logic [DW-1:0] req2_data_in,
  input  logic [DW-1:0] req3_data_in,
  input  logic [DW-1:0] req4_data_in,
  output logic [1:0]    out_resp1,
  output logic [1:0]    out_resp2,
  output logic [1:0]    out_resp3,
  output logic [1:0]    out_resp4,
  output logic [DW-1:0] out_data1,
  output logic [DW-1:0] out_data2,
  output logic [DW-1:0] out_data3,
  output logic [DW-1:0] out_data4,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [3:0]    alu_cmd,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [1:0]    alu_tag,
  input  logic          alu_rsp_valid,
  input  logic [1:0]    alu_rsp,
  input  logic [DW-1:0] alu_rsp_data,
  input  logic [1:0]    alu_rsp_tag
);

  typedef enum logic [2:0] {IDLE, OP2, PEND, WAIT, RESP} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [3:0][3:0]    cmd_in;
  logic [3:0][DW-1:0] data_in;
  assign cmd_in  = {req4_cmd_in, req3_cmd_in, req2_cmd_in, req1_cmd_in};
  assign data_in = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};

  state_t [3:0]       state_q;
  logic [3:0][3:0]    cmd_q;
  logic [3:0][DW-1:0] op1_q;
  logic [3:0][DW-1:0] op2_q;
  logic [3:0][1:0]    resp_q;
  logic [3:0][DW-1:0] rdata_q;
  logic [3:0][TW-1:0] timer_q;
  logic [1:0]         rr_q;
  logic               lock_q;
  logic [1:0]         lock_idx_q;

  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] scan_idx;
  logic       handshake;

  function automatic logic cmd_ok(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // A stalled grant is locked so a port entering PEND ahead of it cannot steal the bus.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    scan_idx  = 2'd0;
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt_idx   = lock_idx_q;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = rr_q + 2'(k);
        if (state_q[scan_idx] == PEND) begin
          gnt_valid = 1'b1;
          gnt_idx   = scan_idx;
        end
      end
    end
  end

  assign handshake = gnt_valid && alu_ready;
  assign alu_valid = gnt_valid;
  assign alu_cmd   = gnt_valid ? cmd_q[gnt_idx] : 4'd0;
  assign alu_op1   = gnt_valid ? op1_q[gnt_idx] : '0;
  assign alu_op2   = gnt_valid ? op2_q[gnt_idx] : '0;
  assign alu_tag   = gnt_valid ? gnt_idx : 2'd0;

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = rdata_q[0];
  assign out_data2 = rdata_q[1];
  assign out_data3 = rdata_q[2];
  assign out_data4 = rdata_q[3];

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) state_q[i] <= IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      resp_q     <= '0;
      rdata_q    <= '0;
      timer_q    <= '0;
      rr_q       <= 2'd0;
      lock_q     <= 1'b0;
      lock_idx_q <= 2'd0;
    end else begin
      if (handshake) begin
        rr_q   <= gnt_idx + 2'd1;
        lock_q <= 1'b0;
      end else if (gnt_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= gnt_idx;
      end
      for (int i = 0; i < 4; i++) begin
        resp_q[i]  <= 2'd0;
        rdata_q[i] <= '0;
        case (state_q[i])
          IDLE: if (cmd_in[i] != 4'd0) begin
            cmd_q[i]   <= cmd_in[i];
            op1_q[i]   <= data_in[i];
            state_q[i] <= OP2;
          end
          OP2: begin
            op2_q[i] <= data_in[i];
            if (cmd_ok(cmd_q[i])) begin
              state_q[i] <= PEND;
            end else begin
              state_q[i] <= RESP;
              resp_q[i]  <= 2'd2;
            end
          end
          PEND: if (handshake && gnt_idx == 2'(i)) begin
            state_q[i] <= WAIT;
            timer_q[i] <= '0;
          end
          WAIT: begin
            // A response landing in the timeout cycle takes priority over the error.
            if (alu_rsp_valid && alu_rsp_tag == 2'(i)) begin
              state_q[i] <= RESP;
              resp_q[i]  <= alu_rsp;
              rdata_q[i] <= alu_rsp_data;
            end else begin
              if (timer_q[i] != TW'(TIMEOUT)) timer_q[i] <= timer_q[i] + 1'b1;
              if (timer_q[i] >= TW'(TIMEOUT - 1)) begin
                state_q[i] <= RESP;
                resp_q[i]  <= 2'd3;
              end
            end
          end
          RESP:    state_q[i] <= IDLE;
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_port_arbiter.sv
// tb/tb_calc_port_arbiter.sv - scoreboard bench for calc_port_arbiter.
// Stimulus pushes hand-computed issues/responses; a negedge monitor pops and compares.
module tb_calc_port_arbiter;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd [4];
  logic [31:0] dat [4];
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_op1, alu_op2;
  logic [1:0]  alu_tag;
  logic        alu_rsp_valid;
  logic [1:0]  alu_rsp;
  logic [31:0] alu_rsp_data;
  logic [1:0]  alu_rsp_tag;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; logic [1:0] tag; int cyc;} iss_t;
  typedef struct {int port; logic [1:0] rsp; logic [31:0] data; int cyc;} rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  calc_port_arbiter #(.TIMEOUT(16), .DW(32)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd[0]), .req2_cmd_in(cmd[1]), .req3_cmd_in(cmd[2]), .req4_cmd_in(cmd[3]),
    .req1_data_in(dat[0]), .req2_data_in(dat[1]), .req3_data_in(dat[2]), .req4_data_in(dat[3]),
    .out_resp1(o_resp[0]), .out_resp2(o_resp[1]), .out_resp3(o_resp[2]), .out_resp4(o_resp[3]),
    .out_data1(o_data[0]), .out_data2(o_data[1]), .out_data3(o_data[2]), .out_data4(o_data[3]),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_tag(alu_tag),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp(alu_rsp), .alu_rsp_data(alu_rsp_data),
    .alu_rsp_tag(alu_rsp_tag)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  always @(negedge c_clk) begin
    if (alu_valid) begin
      if (iss_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: cyc=%0d tag=%0d cmd=%0d", cyc, alu_tag, alu_cmd);
      end else begin
        tests++;
        if (alu_cmd !== iss_q[0].cmd || alu_op1 !== iss_q[0].op1 ||
            alu_op2 !== iss_q[0].op2 || alu_tag !== iss_q[0].tag) begin
          fails++;
          $display("FAIL issue cyc=%0d: got cmd=%0d op1=%h op2=%h tag=%0d, want cmd=%0d op1=%h op2=%h tag=%0d",
                   cyc, alu_cmd, alu_op1, alu_op2, alu_tag,
                   iss_q[0].cmd, iss_q[0].op1, iss_q[0].op2, iss_q[0].tag);
        end
        if (alu_ready) begin
          if (iss_q[0].cyc >= 0) begin
            tests++;
            if (cyc != iss_q[0].cyc) begin
              fails++;
              $display("FAIL issue_cycle tag=%0d: got %0d, want %0d", alu_tag, cyc, iss_q[0].cyc);
            end
          end
          void'(iss_q.pop_front());
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (o_resp[p] != 2'd0) begin
        int idx;
        idx = -1;
        for (int j = rsp_q.size() - 1; j >= 0; j--) if (rsp_q[j].port == p) idx = j;
        if (idx < 0) begin
          fails++;
          $display("FAIL unexpected_resp port%0d: cyc=%0d got resp=%0d data=%h, want none", p + 1, cyc, o_resp[p], o_data[p]);
        end else begin
          tests++;
          if (o_resp[p] !== rsp_q[idx].rsp || o_data[p] !== rsp_q[idx].data || cyc != rsp_q[idx].cyc) begin
            fails++;
            $display("FAIL resp port%0d: got resp=%0d data=%h cyc=%0d, want resp=%0d data=%h cyc=%0d",
                     p + 1, o_resp[p], o_data[p], cyc, rsp_q[idx].rsp, rsp_q[idx].data, rsp_q[idx].cyc);
          end
          rsp_q.delete(idx);
        end
      end else if (o_data[p] != 32'd0) begin
        fails++;
        $display("FAIL idle_data port%0d: cyc=%0d got %h, want 0", p + 1, cyc, o_data[p]);
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      fails++;
      $display("FAIL sequencing: at cyc %0d, want <= %0d", cyc, t);
    end
    while (cyc < t) tick();
  endtask

  task automatic exp_iss(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] t, input int when);
    iss_q.push_back('{cmd: c, op1: a, op2: b, tag: t, cyc: when});
  endtask

  task automatic exp_rsp(input int p, input logic [1:0] r, input logic [31:0] d, input int when);
    rsp_q.push_back('{port: p, rsp: r, data: d, cyc: when});
  endtask

  task automatic alu_reply(input int when, input logic [1:0] t, input logic [1:0] r, input logic [31:0] d);
    wait_cyc(when);
    alu_rsp_valid = 1'b1; alu_rsp_tag = t; alu_rsp = r; alu_rsp_data = d;
    tick();
    alu_rsp_valid = 1'b0; alu_rsp_tag = 2'd0; alu_rsp = 2'd0; alu_rsp_data = 32'd0;
  endtask

  task automatic check_zero(input string name);
    logic [255:0] all;
    all = {alu_valid, alu_cmd, alu_op1, alu_op2, alu_tag,
           o_resp[0], o_resp[1], o_resp[2], o_resp[3],
           o_data[0], o_data[1], o_data[2], o_data[3]};
    tests++;
    if (all != '0) begin
      fails++;
      $display("FAIL %s: outputs not all zero (valid=%0d cmd=%0d resp=%0d/%0d/%0d/%0d)", name,
               alu_valid, alu_cmd, o_resp[0], o_resp[1], o_resp[2], o_resp[3]);
    end
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 4; i++) begin cmd[i] = 4'd0; dat[i] = 32'd0; end
    alu_ready = 1'b1; alu_rsp_valid = 1'b0; alu_rsp = 2'd0; alu_rsp_data = 32'd0; alu_rsp_tag = 2'd0;
    #1;
    check_zero("reset_state");
    #20;
    check_zero("reset_held");
    tick();
    reset = 1'b1;
    tick(); tick();

    // Four ports at once from pointer 0: grants 0,1,2,3.
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      cmd[i] = 4'd1; dat[i] = 32'(i + 1);
      exp_iss(4'd1, 32'(i + 1), 32'((i + 1) * 16), 2'(i), c0 + 2 + i);
      exp_rsp(i, 2'd1, 32'((i + 1) * 17), c0 + 4 + i);
    end
    tick();
    for (int i = 0; i < 4; i++) begin cmd[i] = 4'd0; dat[i] = 32'((i + 1) * 16); end
    tick();
    for (int i = 0; i < 4; i++) dat[i] = 32'd0;
    for (int i = 0; i < 4; i++) alu_reply(c0 + 3 + i, 2'(i), 2'd1, 32'((i + 1) * 17));
    tick(); tick();

    // Single add on port1; moves the pointer to 1.
    c0 = cyc;
    cmd[0] = 4'd1; dat[0] = 32'h0000_0101;
    exp_iss(4'd1, 32'h101, 32'h1010, 2'd0, c0 + 2);
    exp_rsp(0, 2'd1, 32'h0000_1111, c0 + 5);
    tick();
    cmd[0] = 4'd0; dat[0] = 32'h0000_1010;
    tick();
    dat[0] = 32'd0;
    alu_reply(c0 + 4, 2'd0, 2'd1, 32'h0000_1111);
    tick(); tick();

    // Repeat burst from pointer 1: grants 1,2,3,0.
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (k + 1) % 4;
      exp_iss(4'd2, 32'h100 * (p + 1), 32'h10, 2'(p), c0 + 2 + k);
      exp_rsp(p, 2'd1, 32'h100 * (p + 1) - 32'h10, c0 + 4 + k);
    end
    for (int i = 0; i < 4; i++) begin cmd[i] = 4'd2; dat[i] = 32'h100 * (i + 1); end
    tick();
    for (int i = 0; i < 4; i++) begin cmd[i] = 4'd0; dat[i] = 32'h10; end
    tick();
    for (int i = 0; i < 4; i++) dat[i] = 32'd0;
    for (int k = 0; k < 4; k++) alu_reply(c0 + 3 + k, 2'((k + 1) % 4), 2'd1, 32'h100 * (((k + 1) % 4) + 1) - 32'h10);
    tick(); tick();

    // Invalid command on port2: code 2 at cycle 2, no issue.
    c0 = cyc;
    cmd[1] = 4'd3; dat[1] = 32'hDEAD_BEEF;
    exp_rsp(1, 2'd2, 32'd0, c0 + 2);
    tick();
    cmd[1] = 4'd0; dat[1] = 32'h1234_5678;
    tick();
    dat[1] = 32'd0;

    // Port3 sub stalled 5 cycles; port2 enters PEND mid-stall and must wait.
    c0 = c0 + 4;
    wait_cyc(c0);
    cmd[2] = 4'd2; dat[2] = 32'h50;
    exp_iss(4'd2, 32'h50, 32'h8, 2'd2, c0 + 7);
    exp_iss(4'd5, 32'h3, 32'h4, 2'd1, c0 + 8);
    exp_rsp(2, 2'd1, 32'h48, c0 + 10);
    exp_rsp(1, 2'd1, 32'h30, c0 + 11);
    tick();
    cmd[2] = 4'd0; dat[2] = 32'h8;
    tick();
    dat[2] = 32'd0; alu_ready = 1'b0;
    cmd[1] = 4'd5; dat[1] = 32'h3;
    tick();
    cmd[1] = 4'd0; dat[1] = 32'h4;
    tick();
    dat[1] = 32'd0;
    wait_cyc(c0 + 7);
    alu_ready = 1'b1;
    alu_reply(c0 + 9, 2'd2, 2'd1, 32'h48);
    alu_reply(c0 + 10, 2'd1, 2'd1, 32'h30);
    tick(); tick();

    // Ports 1 and 4 in WAIT, answered 4 then 1.
    c0 = cyc;
    cmd[0] = 4'd1; dat[0] = 32'h1000_0000;
    cmd[3] = 4'd2; dat[3] = 32'h0;
    exp_iss(4'd2, 32'h0, 32'h1, 2'd3, c0 + 2);
    exp_iss(4'd1, 32'h1000_0000, 32'h1000_0000, 2'd0, c0 + 3);
    exp_rsp(3, 2'd2, 32'hFFFF_FFFF, c0 + 6);
    exp_rsp(0, 2'd1, 32'h2000_0000, c0 + 7);
    tick();
    cmd[0] = 4'd0; cmd[3] = 4'd0; dat[3] = 32'h1;
    tick();
    dat[0] = 32'd0; dat[3] = 32'd0;
    alu_reply(c0 + 5, 2'd3, 2'd2, 32'hFFFF_FFFF);
    alu_reply(c0 + 6, 2'd0, 2'd1, 32'h2000_0000);
    tick(); tick();

    // Timeout on port1, late response dropped, then a new command completes.
    c0 = cyc;
    cmd[0] = 4'd1; dat[0] = 32'h7;
    exp_iss(4'd1, 32'h7, 32'h8, 2'd0, c0 + 2);
    exp_rsp(0, 2'd3, 32'd0, c0 + 19);
    tick();
    cmd[0] = 4'd0; dat[0] = 32'h8;
    tick();
    dat[0] = 32'd0;
    alu_reply(c0 + 21, 2'd0, 2'd1, 32'h0000_00FF);
    wait_cyc(c0 + 23);
    cmd[0] = 4'd2; dat[0] = 32'h9;
    exp_iss(4'd2, 32'h9, 32'h4, 2'd0, c0 + 25);
    exp_rsp(0, 2'd1, 32'h5, c0 + 27);
    tick();
    cmd[0] = 4'd0; dat[0] = 32'h4;
    tick();
    dat[0] = 32'd0;
    alu_reply(c0 + 26, 2'd0, 2'd1, 32'h5);
    tick(); tick();

    // Response arriving in the timeout cycle wins.
    c0 = cyc;
    cmd[1] = 4'd6; dat[1] = 32'h80;
    exp_iss(4'd6, 32'h80, 32'h2, 2'd1, c0 + 2);
    exp_rsp(1, 2'd1, 32'hAB, c0 + 19);
    tick();
    cmd[1] = 4'd0; dat[1] = 32'h2;
    tick();
    dat[1] = 32'd0;
    alu_reply(c0 + 18, 2'd1, 2'd1, 32'hAB);
    tick(); tick();

    // Reset with port1 in WAIT and port2 stalled in PEND.
    c0 = cyc;
    cmd[0] = 4'd1; dat[0] = 32'h11;
    cmd[1] = 4'd1; dat[1] = 32'h22;
    exp_iss(4'd1, 32'h11, 32'h1, 2'd0, c0 + 2);
    exp_iss(4'd1, 32'h22, 32'h2, 2'd1, -1);
    tick();
    cmd[0] = 4'd0; cmd[1] = 4'd0; dat[0] = 32'h1; dat[1] = 32'h2;
    tick();
    dat[0] = 32'd0; dat[1] = 32'd0;
    wait_cyc(c0 + 3);
    alu_ready = 1'b0;
    wait_cyc(c0 + 5);
    #1;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    iss_q.delete();
    tick(); tick();
    check_zero("reset_hold");
    reset = 1'b1; alu_ready = 1'b1;
    tick();
    alu_reply(cyc, 2'd0, 2'd1, 32'h12);
    alu_reply(cyc, 2'd1, 2'd1, 32'h24);
    tick();
    c0 = cyc;
    cmd[0] = 4'd1; dat[0] = 32'h5;
    exp_iss(4'd1, 32'h5, 32'h6, 2'd0, c0 + 2);
    exp_rsp(0, 2'd1, 32'hB, c0 + 4);
    tick();
    cmd[0] = 4'd0; dat[0] = 32'h6;
    tick();
    dat[0] = 32'd0;
    alu_reply(c0 + 3, 2'd0, 2'd1, 32'hB);
    repeat (5) tick();

    tests++;
    if (iss_q.size() != 0) begin
      fails++;
      $display("FAIL issue_drain: got %0d pending, want 0", iss_q.size());
    end
    tests++;
    if (rsp_q.size() != 0) begin
      fails++;
      $display("FAIL resp_drain: got %0d pending, want 0", rsp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_port_arbiter.md
Name: calc_port_arbiter

Overview:
Front-end controller that shares one single-issue calc ALU between four requester ports. It uses the calc two-cycle request protocol: command plus operand 1 in cycle N, operand 2 in cycle N+1. It buffers one command per port, round-robin arbitrates onto the ALU issue interface, and tags each issue with its port index. ALU responses, which may return out of order, are routed back to the originating port's out_resp/out_data. It sits between the external req*_cmd_in/req*_data_in pins and the ALU core.

Parameters:
TIMEOUT, 16, cycles a port may wait in WAIT before an internal-error response is generated (min 2)
DW, 32, operand/result width

Ports:
c_clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req1_cmd_in..req4_cmd_in  in  4 each  per-port command
req1_data_in..req4_data_in  in  DW each  per-port operand (op1 with cmd, op2 next cycle)
out_resp1..out_resp4  out  2 each  per-port response code
out_data1..out_data4  out  DW each  per-port result
alu_valid  out  1  issue request
alu_ready  in  1  ALU accepts issue when alu_valid && alu_ready
alu_cmd  out  4  issued command
alu_op1, alu_op2  out  DW each  issued operands
alu_tag  out  2  issuing port index (0..3 = port 1..4)
alu_rsp_valid  in  1  ALU response strobe
alu_rsp  in  2  ALU response code
alu_rsp_data  in  DW  ALU result
alu_rsp_tag  in  2  tag of the returning response

Behaviour:
- Reset (reset=0, asynchronous): all port FSMs go to IDLE; RR pointer=0; all outputs 0 (out_resp*, out_data*, alu_valid, alu_cmd, alu_op1/2, alu_tag).
- Valid commands: 1 add, 2 sub, 5 shl, 6 shr. cmd 0 = no-op. Any other nonzero cmd is invalid.
- Response codes: 0 none, 1 success, 2 overflow/underflow/invalid cmd, 3 internal error (timeout).
- Per-port FSM:
  - IDLE: cmd!=0 -> capture cmd and op1 -> OP2.
  - OP2: capture op2 (data pin; cmd pin ignored). If cmd valid -> PEND; if invalid -> RESP with code 2, data 0.
  - PEND: request arbitration. On issue handshake -> WAIT and clear the timer.
  - WAIT: alu_rsp_valid with matching tag -> RESP with alu_rsp and alu_rsp_data. Otherwise, when the timer reaches TIMEOUT -> RESP with code 3, data 0.
  - RESP: drive registered out_resp/out_data for exactly one cycle -> IDLE.
- Nonzero cmd on a port in OP2, PEND, WAIT or RESP is ignored (dropped, no response).
- A new cmd presented in the cycle after RESP (port back in IDLE) is accepted normally.
- out_resp/out_data are 0 in every cycle except the single RESP-driven cycle.
- Arbitration:
  - Round-robin among ports in PEND, starting at the RR pointer.
  - alu_valid and all alu_* outputs are driven from the granted port and held stable until alu_ready.
  - After a handshake, the pointer = granted index + 1 (mod 4). The pointer is unchanged while stalled.
  - The grant must not switch while alu_valid=1 and alu_ready=0.
- Latency (alu_ready=1, no contention):
  - cmd at cycle 0 -> op2 at 1 -> alu_valid at 2.
  - Response arriving at cycle R -> out_resp at R+1.
  - Invalid cmd at cycle 0 -> out_resp=2 at cycle 2.
- At most one outstanding issue per port, so up to 4 issues are in flight. Tags are unique per in-flight issue.
- Response with a tag whose port is not in WAIT (stale after timeout or reset): discarded, no output.
- Response and timeout in the same cycle: the response wins.
- Arithmetic is done entirely by the ALU; this block never modifies data.
- The timer counts 1..TIMEOUT and saturates.

Test Plan:
1. Port1 cmd=1, op1=0x00000101 then op2=0x00001010; ALU returns rsp=1, data=0x00001111, tag=0 -> alu_cmd=1/op1=0x101/op2=0x1010/tag=0 at cycle 2; out_resp1=1, out_data1=0x00001111 for exactly one cycle.
2. All four ports issue add in the same cycle, alu_ready=1, ALU replies in 1 cycle -> grants tag 0,1,2,3 on consecutive cycles; a repeat burst with the pointer at 1 grants 1,2,3,0.
3. Port2 cmd=3 (invalid) -> no alu_valid; out_resp2=2, out_data2=0 at cycle 2. Port3 cmd=2 issued during alu_ready=0 for 5 cycles -> alu_* outputs stable throughout, issued on the first ready cycle.
4. Ports 1 and 4 in WAIT; ALU responds tag=3 (rsp=2, data 0xFFFFFFFF), then tag=0 (rsp=1, data 0x20000000) -> out_resp4=2 first, then out_resp1=1; no cross-routing.
5. TIMEOUT=16, port1 issued, no response -> out_resp1=3, out_data1=0 after 16 cycles in WAIT; a later tag=0 response produces no output; port1 accepts a new command next.
6. reset driven to 0 while ports are in PEND/WAIT -> all outputs 0 immediately; after release, stale ALU responses are dropped, and a fresh port1 add completes normally.
